// File: rtl/bit_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_serializer_if
// Groups the word handshake and the serial stream of bit_serializer.
//   master : upstream/test side. It drives din and din_valid and observes the rest.
//   slave  : serializer side. It accepts din and din_valid and drives din_ready,
//            x, x_valid, last, busy and word_cnt.
// ---------------------------------------------------------------------------
interface bit_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] din;
    logic             din_valid;
    logic             din_ready;
    logic             x;
    logic             x_valid;
    logic             last;
    logic             busy;
    logic [15:0]      word_cnt;

    modport master (
        output din, din_valid,
        input  din_ready, x, x_valid, last, busy, word_cnt
    );

    modport slave (
        input  din, din_valid,
        output din_ready, x, x_valid, last, busy, word_cnt
    );
endinterface

// File: rtl/bit_serializer.sv
// ---------------------------------------------------------------------------
// bit_serializer
// Parallel-to-serial stage that feeds the sequence detector. The block takes
// WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first,
// one bit per clk. When the next word is presented during the LSB cycle it
// streams directly behind the current word, with no idle bit between them.
//
// Ports:
//   clk  : clock. All state updates on posedge.
//   rst  : synchronous active-high reset. It takes priority over an accept.
//   bus  : bit_serializer_if.slave
//          din/din_valid  in  : parallel word and its valid.
//          din_ready      out : a word can be accepted this cycle.
//          x              out : serial bit, or IDLE_BIT when not shifting.
//          x_valid, busy  out : x carries a data bit.
//          last           out : x carries the LSB of the current word.
//          word_cnt       out : completed-word count. It wraps at 16 bits.
// ---------------------------------------------------------------------------
module bit_serializer #(
    parameter int   WIDTH    = 8,
    parameter logic IDLE_BIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    bit_serializer_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_SHIFT = 1'b1
    } state_t;

    state_t          r_state;
    logic [WIDTH-1:0] r_shreg;
    logic [CW-1:0]    r_cnt;      // remaining bits minus 1
    logic [15:0]      r_word_cnt;

    logic w_shift;
    logic w_last;
    logic w_ready;
    logic w_accept;

    // Every output is decoded from registers only. din and din_valid affect
    // only the next state, so the detector never sees a combinational path.
    assign w_shift  = (r_state == S_SHIFT);
    assign w_last   = w_shift && (r_cnt == '0);
    assign w_ready  = !w_shift || w_last;
    assign w_accept = bus.din_valid && w_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_shreg    <= '0;
            r_cnt      <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_accept) begin
                // An accept during the LSB cycle overrides the return to IDLE.
                // The next MSB therefore follows without a gap.
                r_shreg <= bus.din;
                r_cnt   <= CW'(WIDTH - 1);
                r_state <= S_SHIFT;
            end else if (w_shift) begin
                if (r_cnt != '0) begin
                    r_shreg <= {r_shreg[WIDTH-2:0], 1'b0};
                    r_cnt   <= r_cnt - CW'(1);
                end else begin
                    r_state <= S_IDLE;
                end
            end
            // A word completes on its LSB edge, whether or not a new word loads.
            if (w_last)
                r_word_cnt <= r_word_cnt + 16'd1;
        end
    end

    assign bus.x         = w_shift ? r_shreg[WIDTH-1] : IDLE_BIT;
    assign bus.x_valid   = w_shift;
    assign bus.busy      = w_shift;
    assign bus.last      = w_last;
    assign bus.din_ready = w_ready;
    assign bus.word_cnt  = r_word_cnt;
endmodule

// File: doc/bit_serializer.md
Name: bit_serializer

Overview:
- Parallel-to-serial stage directly upstream of the Moore sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and shifts them out MSB-first, one bit per clk, on `x`.
- Back-to-back words stream with no gap, so bit patterns spanning word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: word width in bits; legal values are WIDTH >= 2.
- IDLE_BIT, 0: value driven on x when no word is being shifted.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- din  input  WIDTH  parallel word; sampled only on the accept edge.
- din_valid  input  1  upstream has a word on din.
- din_ready  output  1  block can accept a word this cycle.
- x  output  1  serial bit to the detector input.
- x_valid  output  1  x carries a data bit, not an idle bit.
- last  output  1  x carries bit 0 (the LSB) of the current word.
- busy  output  1  a word is being shifted.
- word_cnt  output  16  count of completed words; wraps.

Behaviour:
- Registers:
  - state: IDLE or SHIFT.
  - shreg: WIDTH bits.
  - cnt: $clog2(WIDTH) bits, holds the remaining bits minus 1.
  - word_cnt: 16 bits.
- Outputs, decoded from registers only (no combinational path from din or din_valid):
  - x = shreg[WIDTH-1] in SHIFT, IDLE_BIT in IDLE.
  - x_valid = busy = (state==SHIFT).
  - last = (state==SHIFT && cnt==0).
  - din_ready = (state==IDLE) || last.
- Reset (rst=1 at posedge): state=IDLE, shreg=0, cnt=0, word_cnt=0.
  - After reset: x=IDLE_BIT, x_valid=0, busy=0, last=0, din_ready=1.
  - rst has priority over everything else, including an accept in the same cycle.
- Accept: at a posedge with din_valid && din_ready && !rst:
  - shreg<=din, cnt<=WIDTH-1, state<=SHIFT.
- Shift: at a posedge in SHIFT with no accept:
  - If cnt!=0: shreg<=shreg<<1 (zero fill) and cnt<=cnt-1.
  - If cnt==0: state<=IDLE.
- Completion: word_cnt increments by 1 at every posedge where last=1 and rst=0, whether or not a new word is accepted on that edge. It wraps 0xFFFF -> 0x0000.
- Latency:
  - A word accepted at edge k drives its MSB on x during cycle k..k+1; the detector samples it at edge k+1.
  - Bit i (counted from the MSB) is sampled at edge k+1+i.
  - A word occupies exactly WIDTH cycles.
- Back-to-back: if din_valid=1 while last=1, the next word loads on that edge. Its MSB follows the previous LSB in the next cycle with no idle bit, and busy stays high.
- Idle: in IDLE with din_valid=0, state holds and x=IDLE_BIT every cycle. The default IDLE_BIT=0 keeps idle gaps from forming 1011 fragments.
- Handshake rules:
  - din_valid may assert or drop in any cycle.
  - A din change while din_valid=1 and din_ready=0 has no effect; only the value at the accept edge is used.
  - Handshake is not required to be sticky.
- Reset mid-word: the word is abandoned and word_cnt is cleared. x returns to IDLE_BIT in the cycle after the reset edge.
- No underflow or overflow conditions exist: cnt never decrements below 0, and accept only occurs while din_ready=1.

Test Plan:
- Reset: assert rst 2 cycles with din_valid=1, din=8'hFF -> x=0, x_valid=0, din_ready=1, word_cnt=0 throughout, and no word is loaded.
- Single word: after reset, present din=8'hB0, din_valid=1 for one cycle -> over the next 8 cycles x=1,0,1,1,0,0,0,0 with x_valid=1. last=1 only on the 8th cycle; then x_valid=0, word_cnt=1, din_ready=1.
- Back-to-back: din_valid held 1, din=8'hB0 then 8'h0B (changed on the last=1 cycle) -> 16 contiguous x_valid cycles x=1011_0000_0000_1011, with no idle bit at the boundary. Expect 2 detector hits downstream and word_cnt=2.
- Stall: in SHIFT, change din every cycle with din_valid=1 -> the shifted bits match only the word captured at the accept edge, and din_ready=1 only on last cycles.
- Reset mid-word: load 8'hFF, assert rst on the 4th data cycle -> the next cycle has x=0, x_valid=0, word_cnt=0, and shifting does not resume after rst drops.
- Wrap and width: force word_cnt to 0xFFFF via 65535 single-cycle words (or a WIDTH=2 fast run), then complete one more word -> word_cnt=0x0000. Separately, a WIDTH=4 instance with din=4'b1011 -> x=1,0,1,1 over 4 cycles.
